// File: rtl/minisys_pkg.sv
// Shared decode constants for the minisys single-cycle MIPS core.
package minisys_pkg;

  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;

  localparam logic [4:0] REG_RA   = 5'd31;
  localparam logic [4:0] REG_ZERO = 5'd0;

  // Logical immediates and sltiu treat the 16-bit field as unsigned.
  function automatic logic op_zext(input logic [5:0] op);
    return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI) || (op == OP_SLTIU);
  endfunction

endpackage

// File: rtl/regfile32.sv
// General register file: two async read ports, one sync write port, async clear, $0 masked.
module regfile32 #(
  parameter int REG_COUNT = 32,
  parameter int DATA_W    = 32,
  parameter int AW        = $clog2(REG_COUNT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [AW-1:0]     i_raddr1,
  input  logic [AW-1:0]     i_raddr2,
  output logic [DATA_W-1:0] o_rdata1,
  output logic [DATA_W-1:0] o_rdata2
);

  logic [REG_COUNT-1:0][DATA_W-1:0] r_regs;

  // Index 0 is never written, so it stays at its cleared value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_regs <= '0;
    end else if (i_we && (i_waddr != '0)) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata1 = (i_raddr1 == '0) ? '0 : r_regs[i_raddr1];
  assign o_rdata2 = (i_raddr2 == '0) ? '0 : r_regs[i_raddr2];

endmodule

// File: rtl/idecode32.sv
// Decode stage: field split, immediate extension, writeback muxing around the register file.
module idecode32
  import minisys_pkg::*;
#(
  parameter int REG_COUNT = 32,
  parameter int DATA_W    = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       Instruction,
  input  logic [DATA_W-1:0] link_addr,
  input  logic [DATA_W-1:0] ALU_result,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              Jal,
  input  logic              RegWrite,
  input  logic              MemtoReg,
  input  logic              RegDst,
  output logic [DATA_W-1:0] Read_data_1,
  output logic [DATA_W-1:0] Read_data_2,
  output logic [DATA_W-1:0] Sign_extend
);

  localparam int AW = $clog2(REG_COUNT);

  logic [5:0]        w_op;
  logic [4:0]        w_rs, w_rt, w_rd, w_waddr;
  logic [15:0]       w_imm;
  logic              w_we;
  logic [DATA_W-1:0] w_wdata;

  assign w_op  = Instruction[31:26];
  assign w_rs  = Instruction[25:21];
  assign w_rt  = Instruction[20:16];
  assign w_rd  = Instruction[15:11];
  assign w_imm = Instruction[15:0];

  assign Sign_extend = op_zext(w_op) ? {{(DATA_W-16){1'b0}}, w_imm}
                                     : {{(DATA_W-16){w_imm[15]}}, w_imm};

  // Jal overrides both the destination and the data source.
  assign w_we    = RegWrite | Jal;
  assign w_waddr = Jal ? REG_RA : (RegDst ? w_rd : w_rt);
  assign w_wdata = Jal ? link_addr : (MemtoReg ? mem_data : ALU_result);

  regfile32 #(
    .REG_COUNT(REG_COUNT),
    .DATA_W   (DATA_W),
    .AW       (AW)
  ) u_rf (
    .clk     (clock),
    .rst_n   (reset),
    .i_we    (w_we),
    .i_waddr (w_waddr[AW-1:0]),
    .i_wdata (w_wdata),
    .i_raddr1(w_rs[AW-1:0]),
    .i_raddr2(w_rt[AW-1:0]),
    .o_rdata1(Read_data_1),
    .o_rdata2(Read_data_2)
  );

endmodule

// File: tb/tb_idecode32.sv
// Randomized + directed bench for idecode32 with a queue-based scoreboard.
module tb_idecode32;

  logic        clock, reset;
  logic [31:0] Instruction, link_addr, ALU_result, mem_data;
  logic        Jal, RegWrite, MemtoReg, RegDst;
  logic [31:0] Read_data_1, Read_data_2, Sign_extend;

  idecode32 dut (
    .clock(clock), .reset(reset), .Instruction(Instruction), .link_addr(link_addr),
    .ALU_result(ALU_result), .mem_data(mem_data), .Jal(Jal), .RegWrite(RegWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .Read_data_1(Read_data_1),
    .Read_data_2(Read_data_2), .Sign_extend(Sign_extend)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string       nm;
    logic [31:0] r1, r2, se;
  } exp_t;

  exp_t        q[$];
  event        chk_ev;
  int          checks = 0;
  int          failures = 0;
  logic [31:0] model[32];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%08h want=%08h", nm, got, want);
    end
  endtask

  // Monitor: pops one expectation per strobe and compares against live outputs.
  initial begin
    exp_t e;
    forever begin
      @(chk_ev);
      #1;
      if (q.size() == 0) begin
        checks++; failures++;
        $display("FAIL scoreboard_underflow got=0 want=1");
      end else begin
        e = q.pop_front();
        chk({e.nm, ".rd1"}, Read_data_1, e.r1);
        chk({e.nm, ".rd2"}, Read_data_2, e.r2);
        chk({e.nm, ".sext"}, Sign_extend, e.se);
      end
    end
  end

  function automatic logic [31:0] mk_r(input logic [5:0] op, input int rs, input int rt, input int rd);
    logic [4:0] a, b, c;
    a = 5'(rs); b = 5'(rt); c = 5'(rd);
    return {op, a, b, c, 11'h020};
  endfunction

  function automatic logic [31:0] mk_i(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
    logic [4:0] a, b;
    a = 5'(rs); b = 5'(rt);
    return {op, a, b, imm};
  endfunction

  function automatic logic [31:0] ref_ext(input logic [31:0] ins);
    int op;
    int imm;
    op  = int'(ins[31:26]);
    imm = int'(ins[15:0]);
    if (op == 12 || op == 13 || op == 14 || op == 11) return 32'(imm);
    if (imm >= 32768) return 32'(imm - 65536);
    return 32'(imm);
  endfunction

  // One decode cycle: drive after falling edge, predict reads, then apply model write at rising edge.
  task automatic step(input string nm, input logic [31:0] ins, input logic rst,
                      input logic jal, input logic rw, input logic m2r, input logic rdst,
                      input logic [31:0] la, input logic [31:0] alu, input logic [31:0] mem);
    exp_t e;
    int   wa;
    logic [31:0] wd;
    @(negedge clock);
    #1;
    Instruction = ins; reset = rst; Jal = jal; RegWrite = rw; MemtoReg = m2r;
    RegDst = rdst; link_addr = la; ALU_result = alu; mem_data = mem;
    if (!rst) foreach (model[i]) model[i] = 32'h0;
    e.nm = nm;
    e.r1 = model[int'(ins[25:21])];
    e.r2 = model[int'(ins[20:16])];
    e.se = ref_ext(ins);
    q.push_back(e);
    #1 -> chk_ev;
    @(posedge clock);
    if (rst && (rw || jal)) begin
      if (jal) wa = 31; else if (rdst) wa = int'(ins[15:11]); else wa = int'(ins[20:16]);
      if (jal) wd = la; else if (m2r) wd = mem; else wd = alu;
      if (wa != 0) model[wa] = wd;
    end
  endtask

  task automatic rd(input string nm, input int rs, input int rt);
    step(nm, mk_r(6'h00, rs, rt, 0), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic sweep(input string nm);
    for (int i = 0; i < 32; i++) rd(nm, i, 31 - i);
  endtask

  initial begin
    foreach (model[i]) model[i] = 32'h0;
    reset = 1'b0; Instruction = '0; link_addr = '0; ALU_result = '0; mem_data = '0;
    Jal = 1'b0; RegWrite = 1'b0; MemtoReg = 1'b0; RegDst = 1'b0;

    // Reset held with a write attempt: must stay cleared.
    step("reset_hold", mk_r(6'h00, 1, 2, 7), 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'hA5A5A5A5, 32'h0);
    sweep("reset_state");

    step("add_r3", mk_r(6'h00, 0, 0, 3), 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h12345678, 32'h0);
    rd("read_r3", 3, 3);
    step("async_clear", mk_r(6'h00, 3, 3, 0), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    rd("after_clear", 3, 0);

    step("wr_zero", mk_r(6'h00, 0, 0, 0), 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'hFFFFFFFF, 32'h0);
    rd("read_zero", 0, 0);

    for (int i = 1; i < 31; i++)
      step("fill", mk_r(6'h00, 0, 0, i), 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h1000 + 32'(i), 32'h0);
    step("jal", mk_i(6'h03, 0, 0, 16'h0101), 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h00000404, 32'h0, 32'hDEADBEEF);
    sweep("jal_sweep");

    step("lw_r5", mk_i(6'h23, 0, 5, 16'h0004), 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 32'hCAFEF00D);
    step("nowr_r5", mk_i(6'h23, 5, 5, 16'h0004), 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h11111111);
    rd("read_r5", 5, 5);

    step("ext_ori", mk_i(6'h0D, 0, 0, 16'h8001), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    step("ext_addi", mk_i(6'h08, 0, 0, 16'h8001), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    step("ext_andi", mk_i(6'h0C, 0, 0, 16'hFFFF), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    step("ext_xori", mk_i(6'h0E, 0, 0, 16'hF00F), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    step("ext_sltiu", mk_i(6'h0B, 0, 0, 16'h8000), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);

    for (int n = 0; n < 400; n++) begin
      logic rst;
      rst = ($urandom_range(0, 49) != 0);
      step("rand", $urandom(), rst, ($urandom_range(0, 7) == 0), $urandom_range(0, 1) == 1,
           $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom(), $urandom(), $urandom());
    end
    sweep("final_sweep");

    @(negedge clock);
    #5;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d want=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
